alu_mul_seq: RTL and testbench

Iterative shift-and-add multiplier sequencer that borrows the processor's shared 32-bit ALU for all of its arithmetic.
- Drives the ALU operand and opcode inputs itself and uses only the ALU ADD (4'b0000) and SLL (4'b0001) encodings.
- Produces the low XLEN bits of op_a*op_b, which is correct for both signed and unsigned MUL.
- Sits beside the single-cycle datapath. While it is busy, alu_grant tells the top-level operand mux to route the ALU inputs from this block.

---
 rtl/alu_mul_seq.sv | 118 +++++++++++
 tb/tb_alu_mul_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that time-shares the datapath ALU (ADD and SLL only).
// Low XLEN bits of op_a*op_b; done 2k+1 cycles after accept; start ignored while busy.
`timescale 1ns/1ps
module alu_mul_seq #(
  parameter int XLEN       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_grant,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;

  logic [XLEN-1:0] w_mplier_shr;
  logic            w_last;

  assign w_mplier_shr = r_mplier >> 1;
  // Early exit looks at the multiplier as it will be after this shift.
  assign w_last = (r_cnt == CW'(XLEN - 1)) || (EARLY_EXIT && (w_mplier_shr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_mplier[0]) r_acc <= alu_res;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_mcand  <= alu_res;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + CW'(1);
            // Result is published on entry to DONE so it is valid alongside done.
            if (w_last) begin
              r_result <= r_acc;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_ADD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (r_state)
      S_ADD: begin
        alu_a = r_acc;
        alu_b = r_mcand;
      end
      S_SHIFT: begin
        alu_a  = r_mcand;
        alu_b  = XLEN'(1);
        alu_op = OP_SLL;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign alu_grant = busy;
  assign done      = (r_state == S_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on/off) each wired to a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_mul_seq;
  logic        clk;
  logic        rst_n;
  logic        start, start0, flush;
  logic [31:0] op_a, op_b;

  logic        busy, done, alu_grant;
  logic [31:0] result, alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  logic        busy0, done0, alu_grant0;
  logic [31:0] result0, alu_a0, alu_b0, alu_res0;
  logic [3:0]  alu_op0;

  int passed = 0;
  int total  = 0;

  assign alu_res  = (alu_op  == 4'b0001) ? (alu_a  << alu_b[4:0])  : (alu_a  + alu_b);
  assign alu_res0 = (alu_op0 == 4'b0001) ? (alu_a0 << alu_b0[4:0]) : (alu_a0 + alu_b0);

  alu_mul_seq #(.XLEN(32), .EARLY_EXIT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .alu_grant(alu_grant), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res)
  );

  alu_mul_seq #(.XLEN(32), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .flush(1'b0),
    .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0), .result(result0),
    .alu_grant(alu_grant0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
    .alu_res(alu_res0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: iteration count is the multiplier's bit length (min 1), or full width.
  function automatic int ref_iters(input logic [31:0] b, input bit no_early);
    if (no_early) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  // Starts one multiply on the chosen instance and checks timing, result and ALU usage.
  task automatic do_mul(input string tag, input bit sel, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int          dcyc, ndone, nbusy;
    bit          ops_ok;
    logic [31:0] res;
    logic        s_busy, s_done, s_grant;
    logic [31:0] s_res, s_a, s_b;
    logic [3:0]  s_op;
    dcyc = -1; ndone = 0; nbusy = 0; ops_ok = 1'b1; res = '0;
    tick();
    op_a = a; op_b = b;
    if (sel) start0 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start0 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      s_busy  = sel ? busy0 : busy;
      s_done  = sel ? done0 : done;
      s_grant = sel ? alu_grant0 : alu_grant;
      s_res   = sel ? result0 : result;
      s_a     = sel ? alu_a0 : alu_a;
      s_b     = sel ? alu_b0 : alu_b;
      s_op    = sel ? alu_op0 : alu_op;
      if (s_busy) nbusy++;
      if (s_grant !== s_busy) ops_ok = 1'b0;
      if (s_done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c;
          res  = s_res;
        end
      end
      if (dcyc < 0 && s_busy) begin
        if (s_op !== ((c % 2 == 1) ? 4'b0000 : 4'b0001)) ops_ok = 1'b0;
      end else if (s_op !== 4'b0000 || s_a !== 32'h0 || s_b !== 32'h0) begin
        ops_ok = 1'b0;
      end
      tick();
    end
    check({tag, "_lat"},   64'(dcyc),   64'(exp_lat));
    check({tag, "_res"},   64'(res),    64'(exp_res));
    check({tag, "_ndone"}, 64'(ndone),  64'd1);
    check({tag, "_busy"},  64'(nbusy),  64'(exp_lat));
    check({tag, "_aluop"}, 64'(ops_ok), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          seen;
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    #12;
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_res",   64'(result),    64'd0);
    check("rst_grant", 64'(alu_grant), 64'd0);
    check("rst_aluop", 64'(alu_op),    64'd0);
    check("rst_alua",  64'(alu_a),     64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    do_mul("basic",  1'b0, 32'd6,         32'd7,         7,  32'd42);
    do_mul("signed", 1'b0, 32'hFFFFFFFD,  32'd5,         7,  32'hFFFFFFF1);
    do_mul("zero_b", 1'b0, 32'h12345678,  32'd0,         3,  32'd0);
    do_mul("full",   1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  65, 32'd1);
    do_mul("noee",   1'b1, 32'd6,         32'd7,         65, 32'd42);

    // Start while busy must be ignored.
    tick();
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    op_a = 32'd100; op_b = 32'd100; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("sb_done", 64'(done),   64'd1);
    check("sb_res",  64'(result), 64'd42);
    tick();
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    check("sb_idle8", 64'(busy), 64'd0);
    tick(); start = 1'b0;
    @(negedge clk);
    check("sb_busy9", 64'(busy), 64'd1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1;
    end
    check("sb2_seen", 64'(seen),   64'd1);
    check("sb2_res",  64'(result), 64'd15);

    // Flush mid-operation: back to IDLE, no done, result untouched.
    tick();
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    @(negedge clk);
    check("fl_idle", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("fl_nodone", 64'(seen),   64'd0);
    check("fl_res",    64'(result), 64'd15);

    // Flush in IDLE also blocks a simultaneous start.
    tick();
    op_a = 32'd2; op_b = 32'd2; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fl_idle_start", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation.
    tick();
    op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",  64'(busy),   64'd0);
    check("ar_res",   64'(result), 64'd0);
    check("ar_grant", 64'(alu_grant), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_mul("rand", 1'b0, ra, rb, 2 * ref_iters(rb, 1'b0) + 1, ref_prod(ra, rb));
    end
    for (int n = 0; n < 3; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_mul("rand0", 1'b1, ra, rb, 2 * ref_iters(rb, 1'b1) + 1, ref_prod(ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
